// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD up/down counter slice.
//   BCD_MAX / BCD_MIN : legal digit range limits
//   bcd_digit_t       : one packed BCD digit
//   dir_e             : count direction (0 = up, 1 = down)
//   bcd_sat()         : clamps a nibble to the legal digit range
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register of the ripple counter.
//   clk, rst  : clock, asynchronous active-high reset
//   step      : advance this digit one position this cycle
//   dir       : 0 = up, 1 = down (direction before any toggle this cycle)
//   load      : synchronous load, overrides step
//   load_val  : digit to load (saturated to 9)
//   q         : current digit value
//   term      : digit is at its terminal value (9 up, 0 down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       term
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_sat(load_val);
    end else if (step) begin
      if (dir == DIR_DOWN) begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end else begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign term = (dir == DIR_DOWN) ? (q_q == BCD_MIN) : (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit packed-BCD up/down counter.
//   DIGITS   : number of BCD digits (1..8)
//   SYNC_TGL : 1 = TGL passes a 2-flop synchroniser, 0 = TGL already in CLK domain
//   CLK, RST : clock, asynchronous active-high reset
//   EN       : count enable, one step per cycle
//   TGL      : direction toggle, each rising edge flips DIR
//   LOAD     : synchronous parallel load (priority over EN)
//   LOAD_VAL : packed BCD load value, digit 0 in [3:0], digits >9 load as 9
//   BCD      : packed BCD count, digit 0 in [3:0]
//   DIR      : 0 = up, 1 = down
//   WRAP     : one-cycle pulse coincident with the wrapped count
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter bit          SYNC_TGL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  TGL,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  DIR,
  output logic                  WRAP
);

  logic sync1_q, sync2_q, prev_q;
  logic tgl_src, tgl_edge;
  dir_e dir_q, dir_d;
  logic wrap_q, wrap_d;

  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   carry;

  // prev_q always tracks the same source the edge is taken from, so the
  // bypass case needs no separate edge flop.
  assign tgl_src  = SYNC_TGL ? sync2_q : TGL;
  assign tgl_edge = tgl_src & ~prev_q;

  assign dir_d = tgl_edge ? ((dir_q == DIR_UP) ? DIR_DOWN : DIR_UP) : dir_q;

  // Ripple enable: a digit steps when EN is high and every lower digit is
  // at its terminal value for the current direction.
  assign carry[0] = EN;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign carry[g+1] = carry[g] & term[g];

    bcd_digit u_digit (
      .clk      (CLK),
      .rst      (RST),
      .step     (carry[g]),
      .dir      (dir_q),
      .load     (LOAD),
      .load_val (LOAD_VAL[4*g +: 4]),
      .q        (BCD[4*g +: 4]),
      .term     (term[g])
    );
  end

  assign wrap_d = carry[DIGITS] & ~LOAD;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      sync1_q <= TGL;
      sync2_q <= sync1_q;
      prev_q  <= tgl_src;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign DIR  = dir_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en  [2];
  logic        tgl [2];
  logic        ld  [2];
  logic [31:0] lv  [2];

  logic [7:0]  bcd2;
  logic [15:0] bcd4;
  logic        dir2, dir4, wrap2, wrap4;

  bcd_updown_counter #(.DIGITS(2), .SYNC_TGL(1'b1)) u_dut2 (
    .CLK(clk), .RST(rst), .EN(en[0]), .TGL(tgl[0]), .LOAD(ld[0]),
    .LOAD_VAL(lv[0][7:0]), .BCD(bcd2), .DIR(dir2), .WRAP(wrap2)
  );

  bcd_updown_counter #(.DIGITS(4), .SYNC_TGL(1'b0)) u_dut4 (
    .CLK(clk), .RST(rst), .EN(en[1]), .TGL(tgl[1]), .LOAD(ld[1]),
    .LOAD_VAL(lv[1][15:0]), .BCD(bcd4), .DIR(dir4), .WRAP(wrap4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count kept as a plain decimal integer.
  localparam int MODV [2] = '{100, 10000};
  localparam int DIGS [2] = '{2, 4};
  localparam bit SYNCK[2] = '{1'b1, 1'b0};

  int m_cnt [2];
  bit m_dir [2];
  bit m_wrap[2];
  bit th1[2], th2[2], th3[2];  // TGL as sampled 1, 2, 3 edges ago

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_dec(input logic [31:0] x, input int d);
    int acc, p, n;
    acc = 0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      n = int'(x[4*i +: 4]);
      if (n > 9) n = 9;
      acc += n * p;
      p *= 10;
    end
    return acc;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_dir[k] = 1'b0; m_wrap[k] = 1'b0;
      th1[k] = 1'b0; th2[k] = 1'b0; th3[k] = 1'b0;
    end
  endtask

  // Called at a rising edge, before inputs change.
  task automatic model_edge(input int k);
    bit flip;
    // TGL rising seen 3 edges later when synchronised, next edge otherwise.
    flip = SYNCK[k] ? (th2[k] && !th3[k]) : (tgl[k] && !th1[k]);
    if (ld[k]) begin
      m_cnt[k]  = load_dec(lv[k], DIGS[k]);
      m_wrap[k] = 1'b0;
    end else if (en[k]) begin
      if (!m_dir[k]) begin
        m_wrap[k] = (m_cnt[k] == MODV[k] - 1);
        m_cnt[k]  = (m_cnt[k] + 1) % MODV[k];
      end else begin
        m_wrap[k] = (m_cnt[k] == 0);
        m_cnt[k]  = (m_cnt[k] + MODV[k] - 1) % MODV[k];
      end
    end else begin
      m_wrap[k] = 1'b0;
    end
    if (flip) m_dir[k] = !m_dir[k];
    th3[k] = th2[k];
    th2[k] = th1[k];
    th1[k] = tgl[k];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("bcd2",  32'(bcd2),  to_bcd(m_cnt[0], 2));
    check("dir2",  32'(dir2),  32'(m_dir[0]));
    check("wrap2", 32'(wrap2), 32'(m_wrap[0]));
    check("bcd4",  32'(bcd4),  to_bcd(m_cnt[1], 4));
    check("dir4",  32'(dir4),  32'(m_dir[1]));
    check("wrap4", 32'(wrap4), 32'(m_wrap[1]));
  endtask

  // Single TGL pulse on the 2-digit unit, then wait for the synchroniser.
  task automatic pulse_tgl2();
    tgl[0] = 1'b1; tick();
    tgl[0] = 1'b0; tick(); tick();
  endtask

  initial begin
    bit done;
    bit ok;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; tgl[k] = 1'b0; ld[k] = 1'b0; lv[k] = '0;
    end
    model_reset();
    #12 rst = 1'b0;

    check("rst_bcd2",  32'(bcd2),  32'h0);
    check("rst_dir2",  32'(dir2),  32'h0);
    check("rst_wrap2", 32'(wrap2), 32'h0);
    check("rst_bcd4",  32'(bcd4),  32'h0);

    // Count up through the wrap.
    en[0] = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 9)   check("up9",    32'(bcd2), 32'h09);
      if (i == 10)  check("up10",   32'(bcd2), 32'h10);
      if (i == 99)  check("up99",   32'(bcd2), 32'h99);
      if (i == 100) begin
        check("up100",  32'(bcd2),  32'h00);
        check("wrap_up", 32'(wrap2), 32'h1);
      end
      if (i == 101) check("wrap_one", 32'(wrap2), 32'h0);
    end
    en[0] = 1'b0;

    // Down wrap and borrow.
    pulse_tgl2();
    check("dir_set", 32'(dir2), 32'h1);
    ld[0] = 1'b1; lv[0] = 32'h01; tick();
    ld[0] = 1'b0; en[0] = 1'b1;
    tick(); check("dn00", 32'(bcd2), 32'h00);
    tick(); check("dn99", 32'(bcd2), 32'h99); check("wrap_dn", 32'(wrap2), 32'h1);
    tick(); check("dn98", 32'(bcd2), 32'h98); check("wrap_dn0", 32'(wrap2), 32'h0);
    en[0] = 1'b0;
    ld[0] = 1'b1; lv[0] = 32'h90; tick();
    ld[0] = 1'b0; en[0] = 1'b1; tick();
    check("borrow", 32'(bcd2), 32'h89);
    en[0] = 1'b0;

    // Held toggle at 0x42: single turnaround on the 3rd edge.
    pulse_tgl2();
    check("dir_up", 32'(dir2), 32'h0);
    ld[0] = 1'b1; lv[0] = 32'h42; tick();
    ld[0] = 1'b0; en[0] = 1'b1; tgl[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) check("tg_dir2", 32'(dir2), 32'h0);
      if (i == 3) begin
        check("tg_bcd3", 32'(bcd2), 32'h45);
        check("tg_dir3", 32'(dir2), 32'h1);
      end
      if (i == 5)  check("tg_bcd5", 32'(bcd2), 32'h43);
      if (i == 10) check("tg_hold", 32'(dir2), 32'h1);
    end
    tgl[0] = 1'b0; tick();
    pulse_tgl2();
    check("tg_back", 32'(dir2), 32'h0);
    en[0] = 1'b0; tick();

    // Load priority and saturation.
    ld[0] = 1'b1; en[0] = 1'b1; lv[0] = 32'h5C; tick();
    check("ld_sat", 32'(bcd2), 32'h59);
    lv[0] = 32'h37; tick();
    check("ld_prio", 32'(bcd2), 32'h37);
    ld[0] = 1'b0; en[0] = 1'b0;

    // Asynchronous reset between edges.
    pulse_tgl2();
    ld[0] = 1'b1; lv[0] = 32'h57; tick();
    ld[0] = 1'b0;
    check("pre_bcd", 32'(bcd2), 32'h57);
    check("pre_dir", 32'(dir2), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_bcd",  32'(bcd2),  32'h00);
    check("arst_dir",  32'(dir2),  32'h0);
    check("arst_wrap", 32'(wrap2), 32'h0);
    model_reset();
    #2 rst = 1'b0;
    en[0] = 1'b1; tick();
    check("arst_resume", 32'(bcd2), 32'h01);
    en[0] = 1'b0;

    // 4-digit full sweep with random enable.
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      en[1] = ($urandom_range(0, 3) != 0);
      tick();
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (bcd4[4*i +: 4] > 4'd9) ok = 1'b0;
      check("digits_ok", 32'(ok), 32'h1);
      if (wrap4) done = 1'b1;
    end
    check("sweep_wrap", 32'(done), 32'h1);
    check("sweep_zero", 32'(bcd4), 32'h0000);

    // Mixed random traffic on both units.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        en[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) tgl[k] = ~tgl[k];
        ld[k] = ($urandom_range(0, 15) == 0);
        lv[k] = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
